// File: rtl/riscm_pkg.sv
// Shared types and constants for the RISC machine fetch/execute blocks.
// Holds the bus command encoding, the fetch sequencer states and the default widths.
package riscm_pkg;

  localparam int RISCM_PC_W   = 9;
  localparam int RISCM_DATA_W = 16;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF1  = 3'd1,
    S_IF2  = 3'd2,
    S_UPD  = 3'd3,
    S_EXEC = 3'd4,
    S_HALT = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter register: a branch load takes priority over increment.
// The increment wraps modulo 2^PC_W.
module pc_unit
  import riscm_pkg::*;
#(
  parameter int               PC_W     = RISCM_PC_W,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer and memory-bus arbiter: fetches into IR, starts the
// execute FSM and lends it the bus while the instruction executes.
module fetch_controller
  import riscm_pkg::*;
#(
  parameter int               PC_W     = RISCM_PC_W,
  parameter int               DATA_W   = RISCM_DATA_W,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        mem_cmd,
  output logic [PC_W-1:0]   mem_addr,
  output logic [DATA_W-1:0] ir,
  output logic [PC_W-1:0]   pc,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic              branch_valid,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              halt_req,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [PC_W-1:0]   data_addr,
  output logic              data_gnt,
  output logic              halted
);

  fetch_state_t state, state_nx;
  mem_cmd_t     cmd;
  logic         exec_first;
  logic         pc_inc;
  logic         pc_load;

  pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .target (branch_target),
    .inc    (pc_inc),
    .pc     (pc)
  );

  // exec_first marks the first S_EXEC cycle: S_UPD always hands over to S_EXEC
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      exec_first <= 1'b0;
      ir         <= '0;
    end else begin
      state      <= state_nx;
      exec_first <= (state == S_UPD);
      if (state == S_IF2) begin
        ir <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cmd      = MNONE;
    mem_addr = pc;
    data_gnt = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_nx = S_IF1;
        end
      end
      S_IF1: begin
        cmd      = MREAD;
        state_nx = S_IF2;
      end
      S_IF2: begin
        cmd      = MREAD;
        state_nx = S_UPD;
      end
      S_UPD: begin
        pc_inc   = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (data_req) begin
          data_gnt = 1'b1;
          mem_addr = data_addr;
          cmd      = data_we ? MWRITE : MREAD;
        end
        // done is only meaningful once the execute FSM has seen exec_start
        if (!exec_first && exec_done) begin
          if (halt_req) begin
            state_nx = S_HALT;
          end else begin
            pc_load  = branch_valid;
            state_nx = run ? S_IF1 : S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign mem_cmd    = cmd;
  assign exec_start = (state == S_EXEC) && exec_first;
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a small synchronous RAM model.
module tb_fetch_controller;

  localparam int PC_W   = 9;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        mem_cmd;
  logic [PC_W-1:0]   mem_addr;
  logic [DATA_W-1:0] ir;
  logic [PC_W-1:0]   pc;
  logic              exec_start;
  logic              exec_done;
  logic              branch_valid;
  logic [PC_W-1:0]   branch_target;
  logic              halt_req;
  logic              data_req;
  logic              data_we;
  logic [PC_W-1:0]   data_addr;
  logic              data_gnt;
  logic              halted;

  logic [DATA_W-1:0] ram [0:511];
  int total = 0;
  int bad   = 0;

  fetch_controller #(.PC_W(PC_W), .DATA_W(DATA_W), .RESET_PC('0)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .mem_rdata     (mem_rdata),
    .mem_cmd       (mem_cmd),
    .mem_addr      (mem_addr),
    .ir            (ir),
    .pc            (pc),
    .exec_start    (exec_start),
    .exec_done     (exec_done),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .data_req      (data_req),
    .data_we       (data_we),
    .data_addr     (data_addr),
    .data_gnt      (data_gnt),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= ram[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    #1;
    total++;
    if (pc !== 9'h000 || ir !== 16'h0000 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: pc=%h ir=%h halted=%b, want 000 0000 0", pc, ir, halted);
    end
    total++;
    if (mem_cmd !== 2'b00 || mem_addr !== 9'h000 || exec_start !== 1'b0 || data_gnt !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus: cmd=%b addr=%h start=%b gnt=%b, want 00 000 0 0",
               mem_cmd, mem_addr, exec_start, data_gnt);
    end
    reset = 1'b1;
    step();
    #1;
    total++;
    if (mem_cmd !== 2'b00 || pc !== 9'h000) begin
      bad++;
      $display("FAIL idle_hold: cmd=%b pc=%h, want 00 000", mem_cmd, pc);
    end
  endtask

  task automatic test_fetch_and_data();
    int n;
    run = 1'b1;
    step();
    data_req = 1'b1; data_we = 1'b1; data_addr = 9'h040;
    #1;
    total++;
    if (mem_cmd !== 2'b01 || mem_addr !== 9'h000 || data_gnt !== 1'b0) begin
      bad++;
      $display("FAIL if1_arb: cmd=%b addr=%h gnt=%b, want 01 000 0", mem_cmd, mem_addr, data_gnt);
    end
    data_req = 1'b0; data_we = 1'b0;
    n = 0;
    while (exec_start !== 1'b1 && n < 20) begin step(); n++; end
    total++;
    if (n != 3 || ir !== 16'hD105 || pc !== 9'h001) begin
      bad++;
      $display("FAIL fetch0: cycles=%0d ir=%h pc=%h, want 3 d105 001", n, ir, pc);
    end
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    #1;
    total++;
    if (exec_start !== 1'b0 || mem_cmd !== 2'b00) begin
      bad++;
      $display("FAIL first_done_ignored: start=%b cmd=%b, want 0 00", exec_start, mem_cmd);
    end
    data_req = 1'b1; data_we = 1'b1; data_addr = 9'h040;
    #1;
    total++;
    if (mem_cmd !== 2'b10 || mem_addr !== 9'h040 || data_gnt !== 1'b1) begin
      bad++;
      $display("FAIL exec_write_gnt: cmd=%b addr=%h gnt=%b, want 10 040 1", mem_cmd, mem_addr, data_gnt);
    end
    data_req = 1'b0; data_we = 1'b0;
    step();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    #1;
    total++;
    if (mem_cmd !== 2'b01 || mem_addr !== 9'h001) begin
      bad++;
      $display("FAIL next_fetch: cmd=%b addr=%h, want 01 001", mem_cmd, mem_addr);
    end
  endtask

  task automatic test_branch();
    int n;
    n = 0;
    while (exec_start !== 1'b1 && n < 20) begin step(); n++; end
    step();
    exec_done = 1'b1; branch_valid = 1'b1; branch_target = 9'h0A0;
    step();
    exec_done = 1'b0; branch_valid = 1'b0;
    #1;
    total++;
    if (mem_cmd !== 2'b01 || mem_addr !== 9'h0A0) begin
      bad++;
      $display("FAIL branch_fetch: cmd=%b addr=%h, want 01 0a0", mem_cmd, mem_addr);
    end
    n = 0;
    while (exec_start !== 1'b1 && n < 20) begin step(); n++; end
    total++;
    if (n != 3 || ir !== 16'h2222 || pc !== 9'h0A1) begin
      bad++;
      $display("FAIL branch_exec: cycles=%0d ir=%h pc=%h, want 3 2222 0a1", n, ir, pc);
    end
  endtask

  task automatic test_wrap();
    int n;
    step();
    exec_done = 1'b1; branch_valid = 1'b1; branch_target = 9'h1FF;
    step();
    exec_done = 1'b0; branch_valid = 1'b0;
    n = 0;
    while (exec_start !== 1'b1 && n < 20) begin step(); n++; end
    total++;
    if (n != 3 || ir !== 16'h3333 || pc !== 9'h000) begin
      bad++;
      $display("FAIL wrap_pc: cycles=%0d ir=%h pc=%h, want 3 3333 000", n, ir, pc);
    end
    step();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    #1;
    total++;
    if (mem_cmd !== 2'b01 || mem_addr !== 9'h000) begin
      bad++;
      $display("FAIL wrap_fetch: cmd=%b addr=%h, want 01 000", mem_cmd, mem_addr);
    end
  endtask

  task automatic test_stop();
    int n;
    n = 0;
    while (exec_start !== 1'b1 && n < 20) begin step(); n++; end
    run = 1'b0;
    step();
    step();
    #1;
    total++;
    if (mem_cmd !== 2'b00 || pc !== 9'h001 || exec_start !== 1'b0) begin
      bad++;
      $display("FAIL stop_wait: cmd=%b pc=%h start=%b, want 00 001 0", mem_cmd, pc, exec_start);
    end
    data_req = 1'b1; data_we = 1'b0; data_addr = 9'h055;
    #1;
    total++;
    if (data_gnt !== 1'b1 || mem_cmd !== 2'b01 || mem_addr !== 9'h055) begin
      bad++;
      $display("FAIL stop_still_exec: gnt=%b cmd=%b addr=%h, want 1 01 055", data_gnt, mem_cmd, mem_addr);
    end
    data_req = 1'b0;
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    step();
    data_req = 1'b1; data_addr = 9'h055;
    #1;
    total++;
    if (data_gnt !== 1'b0 || mem_cmd !== 2'b00 || mem_addr !== 9'h001) begin
      bad++;
      $display("FAIL stop_idle: gnt=%b cmd=%b addr=%h, want 0 00 001", data_gnt, mem_cmd, mem_addr);
    end
    data_req = 1'b0;
  endtask

  task automatic test_halt();
    int n;
    run = 1'b1;
    step();
    n = 0;
    while (exec_start !== 1'b1 && n < 20) begin step(); n++; end
    total++;
    if (n != 3 || ir !== 16'h1111 || pc !== 9'h002) begin
      bad++;
      $display("FAIL halt_fetch: cycles=%0d ir=%h pc=%h, want 3 1111 002", n, ir, pc);
    end
    step();
    exec_done = 1'b1; halt_req = 1'b1; branch_valid = 1'b1; branch_target = 9'h0A0;
    step();
    exec_done = 1'b0; halt_req = 1'b0; branch_valid = 1'b0;
    #1;
    total++;
    if (halted !== 1'b1 || pc !== 9'h002 || mem_cmd !== 2'b00) begin
      bad++;
      $display("FAIL halt_enter: halted=%b pc=%h cmd=%b, want 1 002 00", halted, pc, mem_cmd);
    end
    for (int i = 0; i < 4; i++) step();
    data_req = 1'b1;
    #1;
    total++;
    if (halted !== 1'b1 || mem_cmd !== 2'b00 || data_gnt !== 1'b0 || pc !== 9'h002) begin
      bad++;
      $display("FAIL halt_stay: halted=%b cmd=%b gnt=%b pc=%h, want 1 00 0 002",
               halted, mem_cmd, data_gnt, pc);
    end
    data_req = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    total++;
    if (halted !== 1'b0 || pc !== 9'h000 || ir !== 16'h0000) begin
      bad++;
      $display("FAIL reset_from_halt: halted=%b pc=%h ir=%h, want 0 000 0000", halted, pc, ir);
    end
    run = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    run = 1'b0;
    #1;
    total++;
    if (ir !== 16'h0000 || pc !== 9'h000 || mem_cmd !== 2'b00 || mem_addr !== 9'h000 ||
        exec_start !== 1'b0 || halted !== 1'b0 || data_gnt !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_fetch: ir=%h pc=%h cmd=%b addr=%h start=%b halted=%b gnt=%b, want 0000 000 00 000 0 0 0",
               ir, pc, mem_cmd, mem_addr, exec_start, halted, data_gnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
    ram[9'h000] = 16'hD105;
    ram[9'h001] = 16'h1111;
    ram[9'h0A0] = 16'h2222;
    ram[9'h1FF] = 16'h3333;
    reset = 1'b0; run = 1'b0;
    exec_done = 1'b0; branch_valid = 1'b0; branch_target = '0; halt_req = 1'b0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0;

    test_reset();
    test_fetch_and_data();
    test_branch();
    test_wrap();
    test_stop();
    test_halt();
    test_reset_mid_fetch();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
